// File: rtl/uart_word_rx.sv
// uart_word_rx: 8N1 MSB-first serial receiver packing four bytes into a 32-bit word
//   clk, rst        : clock, asynchronous active-high reset
//   rxd             : serial input, idle high, asynchronous to clk
//   data_out        : received word, first byte in [31:24]
//   data_valid      : data_out holds an unconsumed word
//   data_ready      : consumer accepts the word
//   frame_err       : pulse, stop bit sampled low
//   overrun         : pulse, completed word dropped
//   timeout         : pulse, partial word discarded
//   busy            : bit FSM active or partial word pending
module uart_word_rx #(
    parameter int CLK_DIV      = 27,
    parameter int OVS          = 16,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    output logic [31:0] data_out,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        frame_err,
    output logic        overrun,
    output logic        timeout,
    output logic        busy
);
    localparam int DW   = $clog2(CLK_DIV);
    localparam int CW   = $clog2(OVS);
    localparam int TMAX = TIMEOUT_BITS * OVS;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t      state_q, state_d;
    logic [2:0]  sync_q, sync_d;
    logic [DW-1:0] div_q, div_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  bitn_q, bitn_d;
    logic [7:0]  byte_q, byte_d;
    logic [31:0] word_q, word_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [TW-1:0] idle_q, idle_d;
    logic [31:0] out_q, out_d;
    logic        valid_q, valid_d;
    logic        fe_q, fe_d;
    logic        ov_q, ov_d;
    logic        to_q, to_d;
    logic        rx, fall, tick, half, full;

    assign rx   = sync_q[1];
    assign fall = sync_q[2] & ~sync_q[1];
    assign tick = div_q == DW'(CLK_DIV - 1);
    assign half = tick & (cnt_q == CW'(OVS / 2 - 1));
    assign full = tick & (cnt_q == CW'(OVS - 1));

    always_comb begin
        sync_d  = {sync_q[1:0], rxd};
        state_d = state_q;
        div_d   = tick ? '0 : div_q + 1'b1;
        cnt_d   = tick ? cnt_q + 1'b1 : cnt_q;
        bitn_d  = bitn_q;
        byte_d  = byte_q;
        word_d  = word_q;
        bcnt_d  = bcnt_q;
        idle_d  = '0;
        out_d   = out_q;
        valid_d = valid_q & ~data_ready;
        fe_d    = 1'b0;
        ov_d    = 1'b0;
        to_d    = 1'b0;
        if (state_q == IDLE && bcnt_q != 2'd0) begin
            idle_d = tick ? idle_q + 1'b1 : idle_q;
            if (tick && idle_q == TW'(TMAX - 1)) begin
                to_d   = 1'b1;
                bcnt_d = 2'd0;
                word_d = '0;
                idle_d = '0;
            end
        end
        case (state_q)
            IDLE: if (fall) begin
                state_d = START;
                div_d   = '0;
                cnt_d   = '0;
            end
            START: if (half) begin
                cnt_d   = '0;
                bitn_d  = 3'd0;
                state_d = rx ? IDLE : DATA;
            end
            DATA: if (full) begin
                cnt_d   = '0;
                byte_d  = {byte_q[6:0], rx};
                bitn_d  = bitn_q + 3'd1;
                state_d = bitn_q == 3'd7 ? STOP : DATA;
            end
            STOP: if (full) begin
                cnt_d = '0;
                if (rx) begin
                    state_d = IDLE;
                    word_d  = {word_q[23:0], byte_q};
                    bcnt_d  = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        // holding register frees up on an accept in this same cycle
                        if (!valid_q || data_ready) begin
                            out_d   = {word_q[23:0], byte_q};
                            valid_d = 1'b1;
                        end else begin
                            ov_d = 1'b1;
                        end
                    end
                end else begin
                    state_d = WAIT_HIGH;
                    fe_d    = 1'b1;
                    bcnt_d  = 2'd0;
                    word_d  = '0;
                end
            end
            WAIT_HIGH: if (rx) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sync_q  <= 3'b111;
            div_q   <= '0;
            cnt_q   <= '0;
            bitn_q  <= '0;
            byte_q  <= '0;
            word_q  <= '0;
            bcnt_q  <= '0;
            idle_q  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            bitn_q  <= bitn_d;
            byte_q  <= byte_d;
            word_q  <= word_d;
            bcnt_q  <= bcnt_d;
            idle_q  <= idle_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
            to_q    <= to_d;
        end
    end

    assign data_out   = out_q;
    assign data_valid = valid_q;
    assign frame_err  = fe_q;
    assign overrun    = ov_q;
    assign timeout    = to_q;
    assign busy       = (state_q != IDLE) || (bcnt_q != 2'd0);
endmodule

// File: tb/tb_uart_word_rx.sv
// tb_uart_word_rx: directed table-driven bench for uart_word_rx at CLK_DIV=4, OVS=16
module tb_uart_word_rx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxd = 1'b1;
    logic        data_ready = 1'b1;
    logic [31:0] data_out;
    logic        data_valid, frame_err, overrun, timeout, busy;

    uart_word_rx #(.CLK_DIV(4), .OVS(16), .TIMEOUT_BITS(20)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .data_out(data_out), .data_valid(data_valid),
        .data_ready(data_ready), .frame_err(frame_err), .overrun(overrun),
        .timeout(timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    int nvec = 0, nerr = 0;
    int fe_n = 0, ov_n = 0, to_n = 0, vcyc = 0, xfers = 0;
    logic [31:0] last_x = '0;
    logic rdy = 1'b1;

    always @(negedge clk) if (!rst) begin
        fe_n <= fe_n + int'(frame_err);
        ov_n <= ov_n + int'(overrun);
        to_n <= to_n + int'(timeout);
        vcyc <= vcyc + int'(data_valid);
        if (data_valid && data_ready) begin
            xfers  <= xfers + 1;
            last_x <= data_out;
        end
    end

    typedef struct {
        logic [31:0] word;
        logic [31:0] exp_out;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // one frame, each bit 64 clk; cycle i drives after the i-th edge from entry
    task automatic send_byte(input logic [7:0] b, input logic stop, input int pulse_at, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            int k = i / 64;
            rxd = (k == 0) ? 1'b0 : (k == 9) ? stop : b[8-k];
            data_ready = (i == pulse_at) ? 1'b1 : rdy;
            tick_n(1);
        end
        rxd = 1'b1;
        data_ready = rdy;
    endtask

    task automatic send_word(input logic [31:0] w, input int pulse_at);
        for (int j = 3; j >= 0; j--) send_byte(w[8*j+:8], 1'b1, j == 0 ? pulse_at : -1, 640);
    endtask

    int fe0, ov0, to0, vc0, x0;
    task automatic snap();
        fe0 = fe_n; ov0 = ov_n; to0 = to_n; vc0 = vcyc; x0 = xfers;
    endtask

    initial begin
        vecs[0] = '{32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1] = '{32'h01020304, 32'h01020304};
        vecs[2] = '{32'h00000000, 32'h00000000};
        vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[4] = '{32'h80000001, 32'h80000001};
        vecs[5] = '{32'h7E3C5AA1, 32'h7E3C5AA1};

        #1;
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_valid", {31'b0, data_valid}, 32'h0);
        chk("rst_flags", {29'b0, frame_err, overrun, timeout}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        tick_n(3);
        rst = 1'b0;
        tick_n(20);

        for (int v = 0; v < 6; v++) begin
            snap();
            send_word(vecs[v].word, -1);
            tick_n(10);
            chk($sformatf("vec%0d_xfer_word", v), last_x, vecs[v].exp_out);
            chk($sformatf("vec%0d_data_out", v), data_out, vecs[v].exp_out);
            chk($sformatf("vec%0d_xfers", v), xfers - x0, 1);
            chk($sformatf("vec%0d_valid_cycles", v), vcyc - vc0, 1);
            chk($sformatf("vec%0d_flags", v), (fe_n - fe0) + (ov_n - ov0) + (to_n - to0), 0);
            chk($sformatf("vec%0d_busy", v), {31'b0, busy}, 32'h0);
        end

        snap();
        rxd = 1'b0;
        tick_n(16);
        rxd = 1'b1;
        tick_n(40);
        chk("glitch_busy", {31'b0, busy}, 32'h0);
        tick_n(100);
        chk("glitch_flags", (fe_n - fe0) + (ov_n - ov0) + (to_n - to0), 0);
        chk("glitch_xfers", xfers - x0, 0);

        snap();
        send_byte(8'h11, 1'b1, -1, 640);
        send_byte(8'h22, 1'b0, -1, 640);
        tick_n(128);
        send_word(32'h01020304, -1);
        tick_n(10);
        chk("fe_pulses", fe_n - fe0, 1);
        chk("fe_word", last_x, 32'h01020304);
        chk("fe_xfers", xfers - x0, 1);

        snap();
        rdy = 1'b0;
        data_ready = 1'b0;
        send_word(32'hA5A5A5A5, -1);
        send_word(32'h5A5A5A5A, -1);
        tick_n(10);
        chk("ovr_valid", {31'b0, data_valid}, 32'h1);
        chk("ovr_pulses", ov_n - ov0, 1);
        chk("ovr_data_out", data_out, 32'hA5A5A5A5);
        chk("ovr_no_xfer", xfers - x0, 0);
        data_ready = 1'b1;
        tick_n(1);
        data_ready = 1'b0;
        tick_n(5);
        chk("ovr_one_xfer", xfers - x0, 1);
        chk("ovr_xfer_word", last_x, 32'hA5A5A5A5);
        chk("ovr_valid_low", {31'b0, data_valid}, 32'h0);

        snap();
        send_word(32'h11223344, -1);
        send_word(32'h55667788, 610);
        tick_n(10);
        chk("ovl_no_overrun", ov_n - ov0, 0);
        chk("ovl_valid", {31'b0, data_valid}, 32'h1);
        chk("ovl_data_out", data_out, 32'h55667788);
        chk("ovl_first_xfer", last_x, 32'h11223344);
        rdy = 1'b1;
        data_ready = 1'b1;
        tick_n(5);
        chk("ovl_drained", last_x, 32'h55667788);
        chk("ovl_xfers", xfers - x0, 2);

        snap();
        send_byte(8'h12, 1'b1, -1, 640);
        send_byte(8'h34, 1'b1, -1, 640);
        chk("to_busy_partial", {31'b0, busy}, 32'h1);
        tick_n(1400);
        chk("to_pulses", to_n - to0, 1);
        chk("to_busy", {31'b0, busy}, 32'h0);
        send_word(32'hCAFEBABE, -1);
        tick_n(10);
        chk("to_word", last_x, 32'hCAFEBABE);
        chk("to_xfers", xfers - x0, 1);

        snap();
        send_byte(8'h77, 1'b1, -1, 640);
        send_byte(8'h5C, 1'b1, -1, 288);
        rxd = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_data_out", data_out, 32'h0);
        chk("mid_rst_valid", {31'b0, data_valid}, 32'h0);
        chk("mid_rst_busy", {31'b0, busy}, 32'h0);
        tick_n(3);
        rxd = 1'b1;
        rst = 1'b0;
        tick_n(200);
        chk("mid_rst_flags", (fe_n - fe0) + (ov_n - ov0) + (to_n - to0), 0);
        send_word(32'h0BADF00D, -1);
        tick_n(10);
        chk("mid_rst_word", last_x, 32'h0BADF00D);
        chk("mid_rst_xfers", xfers - x0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
